// File: rtl/axi_rd_arbiter.sv
// Read-channel arbiter: one outstanding read shared by I/D prefetchers, same-cycle handoff on completion.
// Build option ARB_RR_EN selects round-robin conflict resolution instead of D-priority with I-side aging.
module axi_rd_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_rd_req,
  input  logic [1:0]   i_rd_type,
  input  logic [31:0]  i_rd_addr,
  output logic         i_rd_rdy,
  output logic         i_ret_valid,
  output logic         i_ret_half,
  input  logic         d_rd_req,
  input  logic [1:0]   d_rd_type,
  input  logic [31:0]  d_rd_addr,
  output logic         d_rd_rdy,
  output logic         d_ret_valid,
  output logic         d_ret_half,
  output logic [255:0] ret_data,
  output logic         axi_rd_req,
  output logic [1:0]   axi_rd_type,
  output logic [31:0]  axi_rd_addr,
  input  logic         axi_rd_rdy,
  input  logic         axi_ret_valid,
  input  logic         axi_ret_half,
  input  logic [255:0] axi_ret_data
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state, state_nxt;
  logic   owner, owner_nxt;
  logic   win, both, sel, req_any, accept;

`ifdef ARB_RR_EN
  logic last, last_nxt;
`else
  localparam logic [3:0] MAX_AGE = 4'(MAX_WAIT);
  logic [3:0] age, age_nxt;
`endif

  assign ret_data = axi_ret_data;
  assign win      = (state == IDLE) || axi_ret_valid;
  assign both     = i_rd_req && d_rd_req;
  assign req_any  = i_rd_req || d_rd_req;
  assign accept   = win && req_any && axi_rd_rdy;

  // sel: 0 = I-side, 1 = D-side
`ifdef ARB_RR_EN
  assign sel = both ? ~last : d_rd_req;
`else
  assign sel = both ? (age != MAX_AGE) : d_rd_req;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      owner <= 1'b0;
`ifdef ARB_RR_EN
      last  <= 1'b0;
`else
      age   <= 4'd0;
`endif
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
`ifdef ARB_RR_EN
      last  <= last_nxt;
`else
      age   <= age_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
`ifdef ARB_RR_EN
    last_nxt  = last;
`else
    age_nxt   = age;
`endif
    if (accept) begin
      state_nxt = BUSY;
      owner_nxt = sel;
`ifdef ARB_RR_EN
      last_nxt  = sel;
`else
      if (!sel)
        age_nxt = 4'd0;
      else if (both && age != MAX_AGE)
        age_nxt = age + 4'd1;
`endif
    end else if (state == BUSY && axi_ret_valid) begin
      state_nxt = IDLE;
    end
  end

  // Everything except the data bus is held low during reset.
  always_comb begin
    axi_rd_req  = 1'b0;
    axi_rd_type = 2'b00;
    axi_rd_addr = 32'd0;
    i_rd_rdy    = 1'b0;
    d_rd_rdy    = 1'b0;
    i_ret_valid = 1'b0;
    i_ret_half  = 1'b0;
    d_ret_valid = 1'b0;
    d_ret_half  = 1'b0;
    if (resetn) begin
      axi_rd_req  = win && req_any;
      axi_rd_type = sel ? d_rd_type : i_rd_type;
      axi_rd_addr = sel ? d_rd_addr : i_rd_addr;
      i_rd_rdy    = win && i_rd_req && !sel && axi_rd_rdy;
      d_rd_rdy    = win && d_rd_req && sel && axi_rd_rdy;
      i_ret_valid = (state == BUSY) && !owner && axi_ret_valid;
      i_ret_half  = (state == BUSY) && !owner && axi_ret_half;
      d_ret_valid = (state == BUSY) && owner && axi_ret_valid;
      d_ret_half  = (state == BUSY) && owner && axi_ret_half;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed vector table, grant-order sequence, randomized run against a reference model.
module tb_axi_rd_arbiter;
  localparam int MAX_WAIT = 2;

  logic         clk = 1'b0;
  logic         resetn;
  logic         i_rd_req, d_rd_req;
  logic [1:0]   i_rd_type, d_rd_type;
  logic [31:0]  i_rd_addr, d_rd_addr;
  logic         i_rd_rdy, i_ret_valid, i_ret_half;
  logic         d_rd_rdy, d_ret_valid, d_ret_half;
  logic [255:0] ret_data, axi_ret_data;
  logic         axi_rd_req, axi_rd_rdy, axi_ret_valid, axi_ret_half;
  logic [1:0]   axi_rd_type;
  logic [31:0]  axi_rd_addr;

  int errors = 0;
  int checks = 0;

  axi_rd_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .resetn(resetn),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_half(i_ret_half),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_half(d_ret_half),
    .ret_data(ret_data),
    .axi_rd_req(axi_rd_req), .axi_rd_type(axi_rd_type), .axi_rd_addr(axi_rd_addr),
    .axi_rd_rdy(axi_rd_rdy), .axi_ret_valid(axi_ret_valid), .axi_ret_half(axi_ret_half),
    .axi_ret_data(axi_ret_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic        ir; logic [1:0] it; logic [31:0] ia;
    logic        dr; logic [1:0] dt; logic [31:0] da;
    logic        ardy, rv, rh;
    logic        e_ir, e_dr, e_req; logic [31:0] e_addr; logic [1:0] e_type;
    logic        e_iv, e_ih, e_dv, e_dh;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
    d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
    axi_rd_rdy = 0; axi_ret_valid = 0; axi_ret_half = 0;
  endtask

  // Reference model state
  logic m_busy, m_owner_d, m_last_d;
  int   m_lost;

  // Aging / round-robin sequence
  int grants_seen[$];
  int exp_order[6];
  int since;

  // Random run
  logic i_clear, d_clear;
  logic win, d_wins, e_req, e_ir, e_dr;

  initial begin
    resetn = 0;
    drive_idle();
    axi_ret_data = '0;

    //           rstn ir it     ia            dr dt     da         ardy rv rh  e_ir e_dr e_req e_addr        e_type e_iv e_ih e_dv e_dh
    vecs[0]  = '{0, 1, 2'b01, 32'hBFC00000, 0, 2'b00, 32'h0,     1, 1, 1,    0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 2'b01, 32'hBFC00000, 0, 2'b00, 32'h0,     1, 0, 0,    1, 0, 1, 32'hBFC00000, 2'b01, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 2'b00, 32'h0,        0, 2'b00, 32'h0,     1, 0, 0,    0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 0};
    vecs[3]  = vecs[2];
    vecs[4]  = vecs[2];
    vecs[5]  = vecs[2];
    vecs[6]  = '{1, 0, 2'b00, 32'h0,        0, 2'b00, 32'h0,     1, 1, 0,    0, 0, 0, 32'h0,        2'b00, 1, 0, 0, 0};
    vecs[7]  = '{1, 0, 2'b00, 32'h0,        0, 2'b00, 32'h0,     0, 1, 1,    0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 0};
    vecs[8]  = '{1, 1, 2'b01, 32'h1000,     1, 2'b01, 32'h2000,  1, 0, 0,    0, 1, 1, 32'h2000,     2'b01, 0, 0, 0, 0};
    vecs[9]  = '{1, 1, 2'b01, 32'h1000,     0, 2'b00, 32'h0,     1, 0, 0,    0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 0};
    vecs[10] = '{1, 1, 2'b01, 32'h1000,     0, 2'b00, 32'h0,     1, 1, 0,    1, 0, 1, 32'h1000,     2'b01, 0, 0, 1, 0};
    vecs[11] = '{1, 0, 2'b00, 32'h0,        1, 2'b10, 32'h3000,  1, 1, 0,    0, 1, 1, 32'h3000,     2'b10, 1, 0, 0, 0};
    vecs[12] = '{1, 0, 2'b00, 32'h0,        0, 2'b00, 32'h0,     1, 0, 1,    0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 1};
    vecs[13] = vecs[2];
    vecs[14] = '{1, 0, 2'b00, 32'h0,        0, 2'b00, 32'h0,     1, 1, 0,    0, 0, 0, 32'h0,        2'b00, 0, 0, 1, 0};
    vecs[15] = '{1, 0, 2'b00, 32'h0,        1, 2'b00, 32'h4000,  0, 0, 0,    0, 0, 1, 32'h4000,     2'b00, 0, 0, 0, 0};
    vecs[16] = '{1, 1, 2'b01, 32'h5000,     0, 2'b00, 32'h0,     0, 0, 0,    0, 0, 1, 32'h5000,     2'b01, 0, 0, 0, 0};
    vecs[17] = '{1, 0, 2'b00, 32'h0,        1, 2'b01, 32'h6000,  1, 0, 0,    0, 1, 1, 32'h6000,     2'b01, 0, 0, 0, 0};
    vecs[18] = '{0, 0, 2'b00, 32'h0,        1, 2'b01, 32'h6000,  1, 1, 1,    0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 0};
    vecs[19] = '{1, 1, 2'b01, 32'hBFC00000, 0, 2'b00, 32'h0,     1, 1, 1,    1, 0, 1, 32'hBFC00000, 2'b01, 0, 0, 0, 0};

    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      resetn = vecs[n].rstn;
      i_rd_req = vecs[n].ir; i_rd_type = vecs[n].it; i_rd_addr = vecs[n].ia;
      d_rd_req = vecs[n].dr; d_rd_type = vecs[n].dt; d_rd_addr = vecs[n].da;
      axi_rd_rdy = vecs[n].ardy; axi_ret_valid = vecs[n].rv; axi_ret_half = vecs[n].rh;
      axi_ret_data = {8{32'hA5A50000 + 32'(n)}};
      #4;
      chk($sformatf("vec%0d_i_rd_rdy", n), i_rd_rdy, vecs[n].e_ir);
      chk($sformatf("vec%0d_d_rd_rdy", n), d_rd_rdy, vecs[n].e_dr);
      chk($sformatf("vec%0d_axi_rd_req", n), axi_rd_req, vecs[n].e_req);
      if (vecs[n].e_req || !vecs[n].rstn) begin
        chk($sformatf("vec%0d_axi_rd_addr", n), axi_rd_addr, vecs[n].e_addr);
        chk($sformatf("vec%0d_axi_rd_type", n), axi_rd_type, vecs[n].e_type);
      end
      chk($sformatf("vec%0d_i_ret_valid", n), i_ret_valid, vecs[n].e_iv);
      chk($sformatf("vec%0d_i_ret_half", n), i_ret_half, vecs[n].e_ih);
      chk($sformatf("vec%0d_d_ret_valid", n), d_ret_valid, vecs[n].e_dv);
      chk($sformatf("vec%0d_d_ret_half", n), d_ret_half, vecs[n].e_dh);
      chk($sformatf("vec%0d_ret_data", n), ret_data, {8{32'hA5A50000 + 32'(n)}});
    end

    // Grant order with both sides requesting continuously, 3-cycle transactions.
`ifdef ARB_RR_EN
    exp_order = '{1, 0, 1, 0, 1, 0};
`else
    exp_order = '{1, 1, 0, 1, 1, 0};
`endif
    @(posedge clk); #1;
    resetn = 0; drive_idle();
    @(posedge clk); #1;
    resetn = 1;
    since = 5;
    for (int k = 0; k < 40 && grants_seen.size() < 6; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      since++;
      i_rd_req = 1; i_rd_type = 2'b01; i_rd_addr = 32'h100 + 32'(k);
      d_rd_req = 1; d_rd_type = 2'b01; d_rd_addr = 32'h200 + 32'(k);
      axi_rd_rdy = 1; axi_ret_valid = (since == 2); axi_ret_half = 0;
      #4;
      if (i_rd_rdy || d_rd_rdy) begin
        grants_seen.push_back(d_rd_rdy ? 1 : 0);
        since = 0;
      end
    end
    chk("grant_count", 32'(grants_seen.size()), 32'd6);
    for (int g = 0; g < 6 && g < grants_seen.size(); g++)
      chk($sformatf("grant%0d_side", g), 32'(grants_seen[g]), 32'(exp_order[g]));

    // Randomized run against the reference model.
    m_busy = 0; m_owner_d = 0; m_last_d = 0; m_lost = 0;
    i_clear = 0; d_clear = 0;
    drive_idle();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      resetn = (c == 0) ? 1'b0 : ($urandom_range(99) != 0);
      if (i_clear) i_rd_req = 0;
      if (d_clear) d_rd_req = 0;
      if (!i_rd_req && $urandom_range(2) == 0) begin
        i_rd_req = 1; i_rd_type = 2'($urandom_range(2)); i_rd_addr = $urandom;
      end
      if (!d_rd_req && $urandom_range(2) == 0) begin
        d_rd_req = 1; d_rd_type = 2'($urandom_range(2)); d_rd_addr = $urandom;
      end
      axi_rd_rdy    = $urandom_range(1) == 1;
      axi_ret_valid = $urandom_range(3) == 0;
      axi_ret_half  = $urandom_range(3) == 0;
      axi_ret_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      #4;
      win = !m_busy || axi_ret_valid;
`ifdef ARB_RR_EN
      d_wins = d_rd_req && (!i_rd_req || !m_last_d);
`else
      d_wins = d_rd_req && (!i_rd_req || m_lost < MAX_WAIT);
`endif
      e_req = resetn && win && (i_rd_req || d_rd_req);
      e_ir  = e_req && i_rd_req && !d_wins && axi_rd_rdy;
      e_dr  = e_req && d_wins && axi_rd_rdy;
      chk("rnd_axi_rd_req", axi_rd_req, e_req);
      chk("rnd_i_rd_rdy", i_rd_rdy, e_ir);
      chk("rnd_d_rd_rdy", d_rd_rdy, e_dr);
      if (!resetn) begin
        chk("rnd_rst_addr", axi_rd_addr, 32'h0);
        chk("rnd_rst_type", axi_rd_type, 2'b00);
      end else if (e_req) begin
        chk("rnd_axi_rd_addr", axi_rd_addr, d_wins ? d_rd_addr : i_rd_addr);
        chk("rnd_axi_rd_type", axi_rd_type, d_wins ? d_rd_type : i_rd_type);
      end
      chk("rnd_i_ret_valid", i_ret_valid, resetn && m_busy && !m_owner_d && axi_ret_valid);
      chk("rnd_i_ret_half", i_ret_half, resetn && m_busy && !m_owner_d && axi_ret_half);
      chk("rnd_d_ret_valid", d_ret_valid, resetn && m_busy && m_owner_d && axi_ret_valid);
      chk("rnd_d_ret_half", d_ret_half, resetn && m_busy && m_owner_d && axi_ret_half);
      chk("rnd_ret_data", ret_data, axi_ret_data);
      i_clear = e_ir;
      d_clear = e_dr;
      if (!resetn) begin
        m_busy = 0; m_owner_d = 0; m_last_d = 0; m_lost = 0;
      end else if (e_ir || e_dr) begin
        m_busy = 1; m_owner_d = e_dr; m_last_d = e_dr;
        if (e_ir) m_lost = 0;
        else if (i_rd_req && m_lost < MAX_WAIT) m_lost++;
      end else if (m_busy && axi_ret_valid) begin
        m_busy = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
